// File: rtl/tappy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tappy_pkg : shared types and error codes for tappy_rx         |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package tappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PRTY = 2'd2,
        STOP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAR_ODD  = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_NONE = 2'd2
    } parity_t;

    localparam logic [2:0] ERR_START    = 3'd1;
    localparam logic [2:0] ERR_PARITY   = 3'd2;
    localparam logic [2:0] ERR_STOP     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;

endpackage
`default_nettype wire

// File: rtl/tappy_filter.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tappy_filter : 2-flop synchroniser plus FILT-sample filter    |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tappy_filter #(
    parameter int FILT = 3
) (
    input  logic sysclk,
    input  logic reset,
    input  logic i_line,
    output logic o_line
);

    localparam int c_cw = (FILT > 1) ? $clog2(FILT) : 1;

    logic [1:0]      sync_q;
    logic [1:0]      sync_d;
    logic            filt_q;
    logic            filt_d;
    logic [c_cw-1:0] cnt_q;
    logic [c_cw-1:0] cnt_d;

    // cnt_q counts how many consecutive samples have already disagreed
    always_comb begin
        sync_d = {sync_q[0], i_line};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == c_cw'(FILT - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_line = filt_q;

endmodule
`default_nettype wire

// File: rtl/tappy_rx.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tappy_rx : PS/2-style serial receiver with error port & FIFO  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tappy_rx
    import tappy_pkg::*;
#(
    parameter int      WIDTH   = 8,
    parameter parity_t PARITY  = PAR_ODD,
    parameter int      FILT    = 3,
    parameter int      TIMEOUT = 2000,
    parameter int      DEPTH   = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             clk,
    input  logic             dat,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             err,
    output logic [2:0]       err_code
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_bw    = $clog2(WIDTH);
    localparam int              c_ww    = $clog2(TIMEOUT + 1);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic w_clk_f;
    logic w_dat_f;
    logic w_edge;
    logic w_push;
    logic w_pop;
    logic w_full;

    tappy_filter #(.FILT(FILT)) u_clk_filt (
        .sysclk (sysclk),
        .reset  (reset),
        .i_line (clk),
        .o_line (w_clk_f)
    );

    tappy_filter #(.FILT(FILT)) u_dat_filt (
        .sysclk (sysclk),
        .reset  (reset),
        .i_line (dat),
        .o_line (w_dat_f)
    );

    state_t           state_q, state_d;
    logic             clk_prev_q;
    logic [c_bw-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             acc_q, acc_d;
    logic             par_bad_q, par_bad_d;
    logic [c_ww-1:0]  wdog_q, wdog_d;
    logic             err_q, err_d;
    logic [2:0]       code_q, code_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [c_aw-1:0]  wr_q, wr_d;
    logic [c_aw-1:0]  rd_q, rd_d;
    logic [c_aw:0]    cnt_q, cnt_d;

    assign w_edge = clk_prev_q && !w_clk_f;
    assign valid  = (cnt_q != '0);
    assign w_pop  = valid && ready;
    assign w_full = (cnt_q == c_depth);
    assign word   = valid ? mem_q[rd_q] : '0;
    assign err      = err_q;
    assign err_code = code_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        par_bad_d = par_bad_q;
        wdog_d    = '0;
        err_d     = 1'b0;
        code_d    = code_q;
        w_push    = 1'b0;

        if (state_q != IDLE && !w_edge) begin
            wdog_d = wdog_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_edge) begin
                    if (!w_dat_f) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        acc_d     = 1'b0;
                        par_bad_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_START;
                    end
                end
            end
            DATA: begin
                if (w_edge) begin
                    shift_d   = {w_dat_f, shift_q[WIDTH-1:1]};
                    acc_d     = acc_q ^ w_dat_f;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_bw'(WIDTH - 1)) begin
                        state_d = (PARITY == PAR_NONE) ? STOP : PRTY;
                    end
                end
            end
            PRTY: begin
                if (w_edge) begin
                    par_bad_d = (w_dat_f != ((PARITY == PAR_ODD) ? ~acc_q : acc_q));
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (w_edge) begin
                    state_d = IDLE;
                    if (!w_dat_f) begin
                        err_d  = 1'b1;
                        code_d = ERR_STOP;
                    end else if (par_bad_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_PARITY;
                    end else if (w_full && !w_pop) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVERFLOW;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge in the same cycle always wins over the watchdog
        if (state_q != IDLE && !w_edge && wdog_q == c_ww'(TIMEOUT - 1)) begin
            state_d = IDLE;
            wdog_d  = '0;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end
    end

    // A full FIFO may push and pop together: the write lands on the slot being read out
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (w_push) begin
            mem_d[wr_q] = shift_q;
            wr_d        = wr_q + 1'b1;
        end
        if (w_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            acc_q      <= 1'b0;
            par_bad_q  <= 1'b0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            code_q     <= 3'd0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            clk_prev_q <= w_clk_f;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            par_bad_q  <= par_bad_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            code_q     <= code_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge sysclk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_tappy_rx.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_tappy_rx : scoreboard bench for two tappy_rx configurations |
// | Rev 1.0                                                        |
// +--------------------------------------------------------------+
module tb_tappy_rx;
    import tappy_pkg::*;

    localparam int T0   = 2000;
    localparam int F0   = 3;
    localparam int HALF = 8;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       c0 = 1'b1, d0 = 1'b1, r0 = 1'b1;
    logic       c1 = 1'b1, d1 = 1'b1, r1 = 1'b1;
    logic [7:0] w0;
    logic       v0, e0;
    logic [2:0] k0;
    logic [8:0] w1;
    logic       v1, e1;
    logic [2:0] k1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cyc0  = -1;
    int last_fall = 0;
    int wq0[$];
    int eq0[$];
    int wq1[$];
    int eq1[$];

    tappy_rx #(.WIDTH(8), .PARITY(PAR_ODD), .FILT(F0), .TIMEOUT(T0), .DEPTH(4)) dut0 (
        .sysclk(sysclk), .reset(reset), .clk(c0), .dat(d0),
        .word(w0), .valid(v0), .ready(r0), .err(e0), .err_code(k0)
    );

    tappy_rx #(.WIDTH(9), .PARITY(PAR_EVEN), .FILT(3), .TIMEOUT(T0), .DEPTH(4)) dut1 (
        .sysclk(sysclk), .reset(reset), .clk(c1), .dat(d1),
        .word(w1), .valid(v1), .ready(r1), .err(e1), .err_code(k1)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitors: pop the expected response whenever a DUT presents one
    always @(negedge sysclk) begin
        if (!reset) begin
            if (e0) begin
                err_cyc0 = cyc;
                if (eq0.size() == 0) chk("err0_unexpected", int'(k0), 0);
                else                 chk("err0_code", int'(k0), eq0.pop_front());
            end
            if (v0 && r0) begin
                if (wq0.size() == 0) chk("word0_unexpected", int'(w0), -1);
                else                 chk("word0", int'(w0), wq0.pop_front());
            end
            if (e1) begin
                if (eq1.size() == 0) chk("err1_unexpected", int'(k1), 0);
                else                 chk("err1_code", int'(k1), eq1.pop_front());
            end
            if (v1 && r1) begin
                if (wq1.size() == 0) chk("word1_unexpected", int'(w1), -1);
                else                 chk("word1", int'(w1), wq1.pop_front());
            end
        end
    end

    function automatic logic [17:0] f8(input logic [7:0] d, input logic p, input logic s);
        f8 = {7'b0, s, p, d, 1'b0};
    endfunction

    function automatic logic [17:0] f9(input logic [8:0] d, input logic p, input logic s);
        f9 = {6'b0, s, p, d, 1'b0};
    endfunction

    function automatic logic odd8(input logic [7:0] d);
        odd8 = ~^d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Sends bits[0] first; dat changes while clk is high
    task automatic send(input int sel, input logic [17:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) d0 = bits[i]; else d1 = bits[i];
            idle(HALF);
            if (sel == 0) c0 = 1'b0; else c1 = 1'b0;
            last_fall = cyc;
            idle(HALF);
            if (sel == 0) c0 = 1'b1; else c1 = 1'b1;
        end
        if (sel == 0) d0 = 1'b1; else d1 = 1'b1;
        idle(20);
    endtask

    initial begin
        idle(4);
        chk("rst_valid0", int'(v0), 0);
        chk("rst_word0", int'(w0), 0);
        chk("rst_err0", int'(e0), 0);
        chk("rst_code0", int'(k0), 0);
        chk("rst_valid1", int'(v1), 0);
        chk("rst_word1", int'(w1), 0);
        reset = 1'b0;
        idle(10);

        // good frame, then bad parity, then recovery
        wq0.push_back(8'h5A);
        send(0, f8(8'h5A, 1'b1, 1'b1), 11);
        eq0.push_back(ERR_PARITY);
        send(0, f8(8'h5A, 1'b0, 1'b1), 11);
        chk("valid0_after_parity", int'(v0), 0);
        wq0.push_back(8'h1C);
        send(0, f8(8'h1C, odd8(8'h1C), 1'b1), 11);

        // partial frame: start + 3 data bits, then silence
        eq0.push_back(ERR_TIMEOUT);
        send(0, f8(8'h05, 1'b0, 1'b0), 4);
        idle(T0 + 50);
        chk("timeout_latency", err_cyc0 - last_fall, T0 + F0 + 3);
        wq0.push_back(8'hF0);
        send(0, f8(8'hF0, odd8(8'hF0), 1'b1), 11);

        // overflow with consumer stalled, then drain in order
        r0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) wq0.push_back(i);
            else        eq0.push_back(ERR_OVERFLOW);
            send(0, f8(i[7:0], odd8(i[7:0]), 1'b1), 11);
        end
        chk("valid0_full", int'(v0), 1);
        r0 = 1'b1;
        idle(10);
        chk("valid0_drained", int'(v0), 0);
        chk("word0_drained", int'(w0), 0);

        // short clk glitches while idle must be ignored
        for (int g = 0; g < 3; g++) begin
            c0 = 1'b0;
            idle(2);
            c0 = 1'b1;
            idle(10);
        end
        wq0.push_back(8'h33);
        send(0, f8(8'h33, odd8(8'h33), 1'b1), 11);
        eq0.push_back(ERR_STOP);
        send(0, f8(8'h33, odd8(8'h33), 1'b0), 11);

        // 9-bit even-parity instance, with a reset in the middle of a frame
        wq1.push_back(9'h1A5);
        send(1, f9(9'h1A5, 1'b1, 1'b1), 12);
        send(1, f9(9'h0FF, 1'b0, 1'b0), 5);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
        chk("valid1_after_reset", int'(v1), 0);
        chk("err1_after_reset", int'(e1), 0);
        idle(T0 + 50);
        wq1.push_back(9'h0B3);
        send(1, f9(9'h0B3, 1'b1, 1'b1), 12);

        idle(50);
        chk("left_words0", wq0.size(), 0);
        chk("left_errs0", eq0.size(), 0);
        chk("left_words1", wq1.size(), 0);
        chk("left_errs1", eq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tappy_rx.md
# tappy_rx

Parametrised successor to the team's single-byte serial-keyboard receiver. It samples an asynchronous two-wire clock/data line (PS/2 style: start bit, WIDTH data bits LSB first, optional parity bit, stop bit, data valid on the falling edge of `clk`) with the system clock. Malformed frames are reported through an error interface instead of halting simulation, and received words are buffered in a small FIFO with a valid/ready output. It sits between the external pins and any downstream consumer of key codes.

## Interface
- `WIDTH`, 8: data bits per frame, 5..16.
- `PARITY`, `PAR_ODD`: parity mode, one of `PAR_ODD`, `PAR_EVEN`, `PAR_NONE` (from package).
- `FILT`, 3: consecutive equal synchronised samples required before a filtered line changes, ≥1.
- `TIMEOUT`, 2000: `sysclk` cycles allowed between falling edges inside a frame, ≥2.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `sysclk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `clk` in 1: asynchronous serial clock line, idles high.
- `dat` in 1: asynchronous serial data line, idles high.
- `word` out WIDTH: FIFO head data; 0 when empty.
- `valid` out 1: FIFO non-empty.
- `ready` in 1: consumer accepts `word` when `valid && ready`.
- `err` out 1: one-cycle pulse, frame error or drop.
- `err_code` out 3: cause, valid while `err`=1; holds its last value otherwise.

## Operation
- Input path: each line has a 2-flop synchroniser, then a filter. The filtered output changes only after FILT consecutive synchronised samples differ from it. Filtered reset value is 1.
- Falling edge: the filtered `clk` was 1 in the previous cycle and is 0 now. Filtered `dat` is sampled in the same cycle.
- FSM states (package enum): `IDLE`, `DATA`, `PRTY`, `STOP`.
  - `IDLE`: on an edge, `dat`=0 goes to `DATA` (counter cleared, parity accumulator cleared). `dat`=1 reports `ERR_START` and stays in `IDLE`.
  - `DATA`: on an edge, shift `dat` into the MSB of the shift register (right shift) and XOR it into the accumulator. After the WIDTH-th bit, go to `PRTY`, or to `STOP` when `PARITY`=`PAR_NONE`.
  - `PRTY`: on an edge, set `par_bad` if the sampled bit ≠ expected. Expected bit is ~acc for odd, acc for even. Go to `STOP`.
  - `STOP`: on an edge, always return to `IDLE`. Then, in priority order:
    - `dat`=0: report `ERR_STOP`.
    - else `par_bad`: report `ERR_PARITY`.
    - else FIFO full and no pop this cycle: report `ERR_OVERFLOW` and drop the word.
    - else push the word.
- Timeout: in any non-`IDLE` state, a watchdog counts cycles since the last edge. When it reaches TIMEOUT, report `ERR_TIMEOUT`, go to `IDLE` and discard the partial frame.
- Error codes (package): `ERR_START`=1, `ERR_PARITY`=2, `ERR_STOP`=3, `ERR_TIMEOUT`=4, `ERR_OVERFLOW`=5.
- FIFO:
  - Pop on `valid && ready`.
  - Push and pop in the same cycle are both honoured, including when full (count unchanged) and when empty (push only).
  - Order is preserved. Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- Reset: FSM goes to `IDLE`, FIFO is emptied, counters and watchdog are cleared, and filters/synchronisers are set to 1. Reset values: `valid`=0, `word`=0, `err`=0, `err_code`=0. A frame in progress is discarded silently, with no error reported.

## Timing
- Pin to filtered line: 2 cycles (synchroniser) + FILT cycles.
- Stop-bit edge to `valid`=1 (FIFO previously empty): 1 cycle. The push registers on that edge and `valid` is visible in the next cycle.
- `err` asserts in the cycle after the detecting edge or timeout, and lasts exactly one cycle.
- Filtered `clk` low-pulse width must be ≥1 cycle. Frames need `clk` half-period > FILT+2 cycles.

## Structure
- `tappy_pkg`: state enum, parity-mode enum, error-code constants.
- Sub-module `tappy_filter` (synchroniser plus FILT-sample filter, reset value 1), instantiated once per line.
- FSM, watchdog and FIFO live in `tappy_rx`.

## Test plan
- Defaults: send frame 0x5A, odd parity bit 1, stop 1, with `ready`=1 → `valid` pulse with `word`=0x5A, no `err`.
- Same frame with parity bit 0 → `err`=1, `err_code`=2, `valid` stays 0. A following good frame 0x1C is received correctly.
- Start bit, then 3 data bits, then `clk` held high → `err_code`=4 exactly TIMEOUT cycles after the last edge. A following 0xF0 frame is received correctly.
- DEPTH=4, `ready`=0, send 0x01..0x05:
  - Fifth frame gives `err_code`=5.
  - Raising `ready` then drains 0x01..0x04 in order, after which `valid`=0.
- FILT=3, inject 2-cycle low glitches on `clk` while idle → no state change, no `err`. Stop bit 0 on a valid frame → `err_code`=3.
- WIDTH=9, `PARITY`=`PAR_EVEN`, frame 0x1A5 → `word`=0x1A5. Assert `reset` mid-frame → `valid`=0, no `err`, and the next frame is received correctly.
